branch_flush_ctrl: RTL and testbench
====================================

Name: branch_flush_ctrl

Overview:
Sequencing controller for control-flow redirects in the core pipeline. Takes jump (JAL/JALR) and resolved-branch events from the execute stage and drives the PC-target mux selects and the PC load strobe to fetch with a ready handshake. It then flushes a programmable number of wrong-path pipeline slots. It also keeps a saturating redirect counter for performance debug.

Parameters:
FLUSH_SLOTS, 2, number of flush cycles issued after a redirect is accepted (legal 0..7)
CNT_W, 16, width of the redirect statistics counter

Ports:
BFC_CLOCK_50  input  1  core clock; all state updates on rising edge
BFC_RESET_InHigh  input  1  asynchronous, active-high reset
BFC_Jump_En  input  1  execute-stage instruction is JAL or JALR
BFC_Opcode_b3  input  1  opcode bit 3 of that instruction (1=JAL, 0=JALR)
BFC_Branch_En  input  1  execute-stage instruction is a conditional branch
BFC_Branch_Taken  input  1  branch condition result from ALU (valid with Branch_En)
BFC_Stall_In  input  1  global pipeline stall (memory wait)
BFC_Fetch_Ready  input  1  fetch unit can accept a new PC this cycle
BFC_Pc_Load  output  1  redirect valid: fetch loads the target PC
BFC_Mux_b_sel  output  1  target base select: 1=rs1 (JALR), 0=PC (JAL/branch)
BFC_Mux_c_sel  output  1  link select: 1=write PC+4 to rd (jump), 0=none
BFC_Flush  output  1  kill IF/ID and ID/EX contents this cycle
BFC_Busy  output  1  controller not in IDLE
BFC_Redirect_Count  output  CNT_W  number of accepted redirects, saturating

Behaviour:
- Reset (async, any state): state=IDLE, Pc_Load=0, Mux_b_sel=0, Mux_c_sel=0, Flush=0, Busy=0, Redirect_Count=0, slot counter=0, captured kind cleared.
- Moore outputs, decoded from registered state/capture flops only. No combinational path from inputs to outputs.
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - Trigger = Jump_En | (Branch_En & Branch_Taken), sampled only when Stall_In=0.
  - On trigger: capture is_jump=Jump_En and is_jalr=Jump_En & ~Opcode_b3, then go to LOAD. Outputs appear 1 cycle after the trigger edge.
  - Jump_En and Branch_En both high: treated as a jump (is_jump=1). Branch_Taken is ignored.
  - Branch_En with Branch_Taken=0: no action.
  - Stall_In=1: trigger not sampled. The execute stage holds the instruction, so it is accepted on the first unstalled cycle.
- LOAD:
  - Pc_Load=1, Mux_b_sel=is_jalr, Mux_c_sel=is_jump, Busy=1.
  - Held stable until Pc_Load & Fetch_Ready. On that edge: Redirect_Count += 1 (holds at all-ones), slot counter loads FLUSH_SLOTS.
  - Next state after handshake: FLUSH if FLUSH_SLOTS>0, else IDLE.
  - Stall_In has no effect in LOAD.
- FLUSH:
  - Flush=1, Busy=1, Pc_Load=0, mux selects=0.
  - Slot counter decrements on each cycle with Stall_In=0 and freezes while Stall_In=1 (Flush stays high).
  - Return to IDLE on the edge where the counter goes 1->0. Flush is therefore high for exactly FLUSH_SLOTS unstalled cycles.
- Trigger inputs are ignored in LOAD and FLUSH, because those instructions are wrong-path.
- Back-to-back redirects: the first IDLE cycle after FLUSH may accept a new trigger. There is no dead cycle beyond the single IDLE cycle.
- Counter width: slot counter is 3 bits. Redirect_Count wraps never; it saturates.

Test Plan:
- Reset mid-LOAD (Pc_Load=1) -> same cycle, asynchronously, all outputs are 0 and Busy=0. After release, the next trigger works normally.
- JALR (Jump_En=1, Opcode_b3=0), Fetch_Ready=1 -> cycle+1: Pc_Load=1, Mux_b_sel=1, Mux_c_sel=1. Cycles +2..+3: Flush=1. Cycle +4: Busy=0. Redirect_Count=1.
- Taken branch with Fetch_Ready low for 3 cycles -> Pc_Load=1, Mux_b_sel=0, Mux_c_sel=0 held for 4 cycles. Then 2 Flush cycles. Count increments once.
- Not-taken branch (Branch_En=1, Branch_Taken=0), and a trigger arriving while in FLUSH -> no state change, Busy stays or returns to 0, count unchanged.
- Stall_In=1 for 2 cycles during FLUSH with FLUSH_SLOTS=2 -> Flush high for 4 cycles total, then IDLE.
- FLUSH_SLOTS=0 build: JAL accepted -> Pc_Load for one cycle, Flush never asserted, IDLE on the next cycle. Force Redirect_Count to all-ones, then one more redirect -> value unchanged.

Source files
------------

// File: rtl/branch_flush_ctrl_if.sv
// Redirect interface between the execute/fetch side and branch_flush_ctrl.
// The master drives the redirect events and the fetch handshake. The slave returns the redirect controls.
interface branch_flush_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             BFC_Jump_En;
    logic             BFC_Opcode_b3;
    logic             BFC_Branch_En;
    logic             BFC_Branch_Taken;
    logic             BFC_Stall_In;
    logic             BFC_Fetch_Ready;
    logic             BFC_Pc_Load;
    logic             BFC_Mux_b_sel;
    logic             BFC_Mux_c_sel;
    logic             BFC_Flush;
    logic             BFC_Busy;
    logic [CNT_W-1:0] BFC_Redirect_Count;

    modport master (
        output BFC_Jump_En, BFC_Opcode_b3, BFC_Branch_En, BFC_Branch_Taken,
               BFC_Stall_In, BFC_Fetch_Ready,
        input  BFC_Pc_Load, BFC_Mux_b_sel, BFC_Mux_c_sel, BFC_Flush, BFC_Busy,
               BFC_Redirect_Count
    );

    modport slave (
        input  BFC_Jump_En, BFC_Opcode_b3, BFC_Branch_En, BFC_Branch_Taken,
               BFC_Stall_In, BFC_Fetch_Ready,
        output BFC_Pc_Load, BFC_Mux_b_sel, BFC_Mux_c_sel, BFC_Flush, BFC_Busy,
               BFC_Redirect_Count
    );
endinterface

// File: rtl/branch_flush_ctrl.sv
// Redirect sequencer: captures a jump/taken branch and loads the target PC into fetch.
// It then flushes FLUSH_SLOTS wrong-path cycles. All outputs are Moore-decoded from flops.
module branch_flush_ctrl #(
    parameter int FLUSH_SLOTS = 2,
    parameter int CNT_W       = 16
) (
    input  logic              BFC_CLOCK_50,
    input  logic              BFC_RESET_InHigh,
    branch_flush_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] SLOT_INIT = 3'(FLUSH_SLOTS);

    state_t           state_q, state_d;
    logic             is_jump_q, is_jump_d;
    logic             is_jalr_q, is_jalr_d;
    logic [2:0]       slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge BFC_CLOCK_50 or posedge BFC_RESET_InHigh) begin
        if (BFC_RESET_InHigh) begin
            state_q   <= IDLE;
            is_jump_q <= 1'b0;
            is_jalr_q <= 1'b0;
            slot_q    <= 3'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_jump_q <= is_jump_d;
            is_jalr_q <= is_jalr_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
        end
    end

    // NOTE: every _d signal gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        state_d   = state_q;
        is_jump_d = is_jump_q;
        is_jalr_d = is_jalr_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.BFC_Stall_In &&
                    (bus.BFC_Jump_En || (bus.BFC_Branch_En && bus.BFC_Branch_Taken))) begin
                    is_jump_d = bus.BFC_Jump_En;
                    is_jalr_d = bus.BFC_Jump_En && !bus.BFC_Opcode_b3;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (bus.BFC_Fetch_Ready) begin
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                    slot_d  = SLOT_INIT;
                    state_d = (FLUSH_SLOTS > 0) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                // A stall freezes the slot count, so only unstalled cycles retire wrong-path slots.
                if (!bus.BFC_Stall_In) begin
                    slot_d = slot_q - 3'd1;
                    if (slot_q <= 3'd1) begin
                        slot_d  = 3'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.BFC_Pc_Load        = (state_q == LOAD);
        bus.BFC_Mux_b_sel      = (state_q == LOAD) && is_jalr_q;
        bus.BFC_Mux_c_sel      = (state_q == LOAD) && is_jump_q;
        bus.BFC_Flush          = (state_q == FLUSH);
        bus.BFC_Busy           = (state_q != IDLE);
        bus.BFC_Redirect_Count = cnt_q;
    end
endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Scoreboard bench for branch_flush_ctrl: instance A uses default parameters.
// Instance B uses FLUSH_SLOTS=0 and a 2-bit counter so that the counter reaches saturation.
module tb_branch_flush_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_n = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [15:0] exp_cnt_a = 16'd0;

    // flags = {Pc_Load, Mux_b_sel, Mux_c_sel, Flush, Busy}
    localparam logic [4:0] F_IDLE  = 5'b00000;
    localparam logic [4:0] F_JALR  = 5'b11101;
    localparam logic [4:0] F_JAL   = 5'b10101;
    localparam logic [4:0] F_BR    = 5'b10001;
    localparam logic [4:0] F_FLUSH = 5'b00011;

    branch_flush_ctrl_if #(.CNT_W(16)) ifa ();
    branch_flush_ctrl_if #(.CNT_W(2))  ifb ();

    branch_flush_ctrl #(.FLUSH_SLOTS(2), .CNT_W(16)) dut (
        .BFC_CLOCK_50    (clk),
        .BFC_RESET_InHigh(rst),
        .bus             (ifa)
    );

    branch_flush_ctrl #(.FLUSH_SLOTS(0), .CNT_W(2)) dut0 (
        .BFC_CLOCK_50    (clk),
        .BFC_RESET_InHigh(rst),
        .bus             (ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Scoreboard: one expected output vector per cycle, tagged with the cycle it applies to.
    int          sb_cyc[$];
    bit          sb_sel[$];
    logic [4:0]  sb_flags[$];
    logic [15:0] sb_cnt[$];
    string       sb_name[$];

    always @(negedge clk) begin
        while (sb_cyc.size() > 0 && sb_cyc[0] <= cyc_n) begin
            automatic int          e_cyc   = sb_cyc.pop_front();
            automatic bit          e_sel   = sb_sel.pop_front();
            automatic logic [4:0]  e_flags = sb_flags.pop_front();
            automatic logic [15:0] e_cnt   = sb_cnt.pop_front();
            automatic string       e_name  = sb_name.pop_front();
            automatic logic [4:0]  a_flags;
            automatic logic [15:0] a_cnt;
            if (e_sel) begin
                a_flags = {ifb.BFC_Pc_Load, ifb.BFC_Mux_b_sel, ifb.BFC_Mux_c_sel,
                           ifb.BFC_Flush, ifb.BFC_Busy};
                a_cnt   = {14'd0, ifb.BFC_Redirect_Count};
            end else begin
                a_flags = {ifa.BFC_Pc_Load, ifa.BFC_Mux_b_sel, ifa.BFC_Mux_c_sel,
                           ifa.BFC_Flush, ifa.BFC_Busy};
                a_cnt   = ifa.BFC_Redirect_Count;
            end
            n_cmp++;
            if (e_cyc != cyc_n || a_flags !== e_flags || a_cnt !== e_cnt) begin
                n_bad++;
                $display("FAIL %s @cyc %0d (due %0d): got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                         e_name, cyc_n, e_cyc, a_flags, a_cnt, e_flags, e_cnt);
            end
        end
    end

    task automatic drive(input bit sel, input logic j, op3, br, tk, st, fr);
        ifa.BFC_Jump_En = 1'b0; ifa.BFC_Opcode_b3 = 1'b0; ifa.BFC_Branch_En = 1'b0;
        ifa.BFC_Branch_Taken = 1'b0; ifa.BFC_Stall_In = 1'b0; ifa.BFC_Fetch_Ready = 1'b0;
        ifb.BFC_Jump_En = 1'b0; ifb.BFC_Opcode_b3 = 1'b0; ifb.BFC_Branch_En = 1'b0;
        ifb.BFC_Branch_Taken = 1'b0; ifb.BFC_Stall_In = 1'b0; ifb.BFC_Fetch_Ready = 1'b0;
        if (sel) begin
            ifb.BFC_Jump_En = j; ifb.BFC_Opcode_b3 = op3; ifb.BFC_Branch_En = br;
            ifb.BFC_Branch_Taken = tk; ifb.BFC_Stall_In = st; ifb.BFC_Fetch_Ready = fr;
        end else begin
            ifa.BFC_Jump_En = j; ifa.BFC_Opcode_b3 = op3; ifa.BFC_Branch_En = br;
            ifa.BFC_Branch_Taken = tk; ifa.BFC_Stall_In = st; ifa.BFC_Fetch_Ready = fr;
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the coming edge.
    task automatic step(input bit sel, input logic j, op3, br, tk, st, fr,
                        input logic [4:0] flags, input logic [15:0] cnt, input string name);
        drive(sel, j, op3, br, tk, st, fr);
        sb_cyc.push_back(cyc_n + 1);
        sb_sel.push_back(sel);
        sb_flags.push_back(flags);
        sb_cnt.push_back(cnt);
        sb_name.push_back(name);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({ifa.BFC_Pc_Load, ifa.BFC_Mux_b_sel, ifa.BFC_Mux_c_sel, ifa.BFC_Flush,
             ifa.BFC_Busy} !== F_IDLE || ifa.BFC_Redirect_Count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: got pl=%b fl=%b busy=%b cnt=%0d, want all 0",
                     ifa.BFC_Pc_Load, ifa.BFC_Flush, ifa.BFC_Busy, ifa.BFC_Redirect_Count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 0, 0, 0, 0, 0, 1, F_IDLE, 16'd0, "idle_after_reset");
    endtask

    task automatic test_jalr;
        step(1'b0, 1, 0, 0, 0, 0, 1, F_JALR, exp_cnt_a, "jalr_load");
        exp_cnt_a++;
        step(1'b0, 0, 0, 0, 0, 0, 1, F_FLUSH, exp_cnt_a, "jalr_flush1");
        step(1'b0, 0, 0, 0, 0, 0, 1, F_FLUSH, exp_cnt_a, "jalr_flush2");
        step(1'b0, 0, 0, 0, 0, 0, 1, F_IDLE,  exp_cnt_a, "jalr_idle");
    endtask

    task automatic test_branch_wait_ready;
        step(1'b0, 0, 0, 1, 1, 0, 0, F_BR, exp_cnt_a, "br_load0");
        for (int i = 0; i < 3; i++)
            step(1'b0, 0, 0, 0, 0, 0, 0, F_BR, exp_cnt_a, "br_load_held");
        exp_cnt_a++;
        step(1'b0, 0, 0, 0, 0, 0, 1, F_FLUSH, exp_cnt_a, "br_flush1");
        step(1'b0, 0, 0, 0, 0, 0, 0, F_FLUSH, exp_cnt_a, "br_flush2");
        step(1'b0, 0, 0, 0, 0, 0, 0, F_IDLE,  exp_cnt_a, "br_idle");
    endtask

    task automatic test_no_action;
        step(1'b0, 0, 0, 1, 0, 0, 1, F_IDLE, exp_cnt_a, "not_taken");
        step(1'b0, 1, 1, 0, 0, 1, 1, F_IDLE, exp_cnt_a, "stalled_trigger");
        step(1'b0, 1, 1, 1, 0, 0, 0, F_JAL,  exp_cnt_a, "jump_and_branch");
        exp_cnt_a++;
        step(1'b0, 1, 0, 1, 1, 0, 1, F_FLUSH, exp_cnt_a, "trig_in_load_ignored");
        step(1'b0, 1, 0, 1, 1, 0, 1, F_FLUSH, exp_cnt_a, "trig_in_flush1");
        step(1'b0, 1, 0, 1, 1, 0, 1, F_IDLE,  exp_cnt_a, "trig_in_flush2");
        step(1'b0, 0, 0, 0, 0, 0, 1, F_IDLE,  exp_cnt_a, "quiet_idle");
    endtask

    task automatic test_flush_stall;
        step(1'b0, 1, 1, 0, 0, 0, 1, F_JAL, exp_cnt_a, "fs_load");
        exp_cnt_a++;
        step(1'b0, 0, 0, 0, 0, 0, 1, F_FLUSH, exp_cnt_a, "fs_flush1");
        step(1'b0, 0, 0, 0, 0, 1, 1, F_FLUSH, exp_cnt_a, "fs_stall1");
        step(1'b0, 0, 0, 0, 0, 1, 1, F_FLUSH, exp_cnt_a, "fs_stall2");
        step(1'b0, 0, 0, 0, 0, 0, 1, F_FLUSH, exp_cnt_a, "fs_flush2");
        step(1'b0, 0, 0, 0, 0, 0, 1, F_IDLE,  exp_cnt_a, "fs_idle");
    endtask

    task automatic test_back_to_back;
        step(1'b0, 1, 0, 0, 0, 0, 1, F_JALR, exp_cnt_a, "b2b_load1");
        exp_cnt_a++;
        step(1'b0, 0, 0, 0, 0, 0, 1, F_FLUSH, exp_cnt_a, "b2b_flush1a");
        step(1'b0, 0, 0, 0, 0, 0, 1, F_FLUSH, exp_cnt_a, "b2b_flush1b");
        step(1'b0, 0, 0, 0, 0, 0, 1, F_IDLE,  exp_cnt_a, "b2b_idle");
        step(1'b0, 0, 0, 1, 1, 0, 1, F_BR,    exp_cnt_a, "b2b_load2");
        exp_cnt_a++;
        step(1'b0, 0, 0, 0, 0, 0, 1, F_FLUSH, exp_cnt_a, "b2b_flush2a");
        step(1'b0, 0, 0, 0, 0, 0, 1, F_FLUSH, exp_cnt_a, "b2b_flush2b");
        step(1'b0, 0, 0, 0, 0, 0, 1, F_IDLE,  exp_cnt_a, "b2b_idle2");
    endtask

    task automatic test_zero_slots_saturate;
        logic [15:0] exp_b = 16'd0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1, 1, 0, 0, 0, 0, F_JAL, exp_b, "z_load");
            if (exp_b != 16'd3) exp_b++;
            step(1'b1, 0, 0, 0, 0, 0, 1, F_IDLE, exp_b, "z_idle_no_flush");
        end
    endtask

    task automatic test_reset_mid_load;
        step(1'b0, 1, 0, 0, 0, 0, 0, F_JALR, exp_cnt_a, "rml_load");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ifa.BFC_Pc_Load, ifa.BFC_Mux_b_sel, ifa.BFC_Mux_c_sel, ifa.BFC_Flush,
             ifa.BFC_Busy} !== F_IDLE || ifa.BFC_Redirect_Count !== 16'd0) begin
            n_bad++;
            $display("FAIL async_reset_mid_load: got pl=%b mb=%b mc=%b busy=%b cnt=%0d, want all 0",
                     ifa.BFC_Pc_Load, ifa.BFC_Mux_b_sel, ifa.BFC_Mux_c_sel, ifa.BFC_Busy,
                     ifa.BFC_Redirect_Count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt_a = 16'd0;
        test_jalr();
    endtask

    initial begin
        test_reset();
        test_jalr();
        test_branch_wait_ready();
        test_no_action();
        test_flush_stall();
        test_back_to_back();
        test_zero_slots_saturate();
        test_reset_mid_load();
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (sb_cyc.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_cyc.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
